// File: rtl/xpb_pkg.sv
// Shared definitions for the xpb table generator, the loadable xpb RAM and the reducer.
// Widths, table depth, generator state encoding and entry/index types live here.
package xpb_pkg;

    localparam int DATA_W    = 1024;
    localparam int IDX_W     = 5;
    localparam int XPB_DEPTH = 1 << IDX_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ADD,
        S_RED,
        S_FIN
    } xpb_state_t;

    typedef logic [DATA_W-1:0] xpb_entry_t;
    typedef logic [IDX_W-1:0]  xpb_idx_t;

    // One write beat into the xpb RAM, as seen by the consumer side.
    typedef struct packed {
        logic       en;
        xpb_idx_t   addr;
        xpb_entry_t data;
    } xpb_wr_t;

endpackage

// File: rtl/xpb_mod_acc.sv
// Modular accumulator: sum = acc + base with carry kept, then acc = sum mod N by one
// conditional subtract. red_val is the reduced value that acc takes on a reduce cycle.
module xpb_mod_acc
    import xpb_pkg::*;
#(
    parameter int DATA_W = xpb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_zero,
    input  logic              add,
    input  logic              reduce,
    input  logic [DATA_W-1:0] base_r,
    input  logic [DATA_W-1:0] mod_r,
    output logic [DATA_W-1:0] red_val
);

    logic [DATA_W-1:0] acc;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   mod_ext;

    assign mod_ext = {1'b0, mod_r};

    // acc < N and base < N, so one subtract always brings sum back below N.
    always_comb begin
        red_val = sum[DATA_W-1:0];
        if (sum >= mod_ext)
            red_val = DATA_W'(sum - mod_ext);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            sum <= '0;
        end else begin
            if (load_zero)
                acc <= '0;
            else if (reduce)
                acc <= red_val;
            if (add)
                sum <= {1'b0, acc} + {1'b0, base_r};
        end
    end

endmodule

// File: rtl/xpb_table_gen.sv
// Streams entry[j] = (j * base) mod modulus, j = 0..2^IDX_W-1, to a loadable xpb RAM.
// One entry every two cycles after the zero entry; base >= modulus aborts with err.
module xpb_table_gen
    import xpb_pkg::*;
#(
    parameter int DATA_W = xpb_pkg::DATA_W,
    parameter int IDX_W  = xpb_pkg::IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] modulus,
    input  logic [DATA_W-1:0] base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'((1 << IDX_W) - 1);

    xpb_state_t        state, nxt_state;
    logic [IDX_W-1:0]  j, nxt_j;
    logic [DATA_W-1:0] mod_r, nxt_mod_r;
    logic [DATA_W-1:0] base_r, nxt_base_r;
    logic              nxt_busy, nxt_done, nxt_err, nxt_wr_en;
    logic [IDX_W-1:0]  nxt_wr_addr;
    logic [DATA_W-1:0] nxt_wr_data;
    logic              load_zero, add, reduce;
    logic [DATA_W-1:0] red_val;

    xpb_mod_acc #(.DATA_W(DATA_W)) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_zero (load_zero),
        .add       (add),
        .reduce    (reduce),
        .base_r    (base_r),
        .mod_r     (mod_r),
        .red_val   (red_val)
    );

    always_comb begin
        nxt_state   = state;
        nxt_j       = j;
        nxt_mod_r   = mod_r;
        nxt_base_r  = base_r;
        nxt_busy    = busy;
        nxt_done    = 1'b0;
        nxt_err     = err;
        nxt_wr_en   = 1'b0;
        nxt_wr_addr = wr_addr;
        nxt_wr_data = wr_data;
        load_zero   = 1'b0;
        add         = 1'b0;
        reduce      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    nxt_mod_r  = modulus;
                    nxt_base_r = base;
                    nxt_err    = 1'b0;
                    nxt_busy   = 1'b1;
                    nxt_state  = S_CHECK;
                end
            end
            S_CHECK: begin
                // Precondition violations are reported, never corrected; N = 0 lands here too.
                if (base_r >= mod_r) begin
                    nxt_err   = 1'b1;
                    nxt_state = S_FIN;
                end else begin
                    nxt_wr_en   = 1'b1;
                    nxt_wr_addr = '0;
                    nxt_wr_data = '0;
                    load_zero   = 1'b1;
                    nxt_j       = IDX_W'(1);
                    nxt_state   = S_ADD;
                end
            end
            S_ADD: begin
                add       = 1'b1;
                nxt_state = S_RED;
            end
            S_RED: begin
                reduce      = 1'b1;
                nxt_wr_en   = 1'b1;
                nxt_wr_addr = j;
                nxt_wr_data = red_val;
                if (j == LAST_IDX) begin
                    nxt_state = S_FIN;
                end else begin
                    nxt_j     = j + IDX_W'(1);
                    nxt_state = S_ADD;
                end
            end
            S_FIN: begin
                nxt_done  = 1'b1;
                nxt_busy  = 1'b0;
                nxt_state = S_IDLE;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            j       <= '0;
            mod_r   <= '0;
            base_r  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state   <= nxt_state;
            j       <= nxt_j;
            mod_r   <= nxt_mod_r;
            base_r  <= nxt_base_r;
            busy    <= nxt_busy;
            done    <= nxt_done;
            err     <= nxt_err;
            wr_en   <= nxt_wr_en;
            wr_addr <= nxt_wr_addr;
            wr_data <= nxt_wr_data;
        end
    end

endmodule

// File: tb/tb_xpb_table_gen.sv
// Scoreboard bench for xpb_table_gen: stimulus queues expected writes/done events with
// their cycle numbers; a negedge monitor pops and compares whatever the DUT presents.
module tb_xpb_table_gen;

    localparam int W = 1024;

    typedef struct {
        bit           is_done;
        logic [4:0]   addr;
        logic [W-1:0] data;
        bit           err;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] modulus = '0;
    logic [W-1:0] base = '0;
    logic         busy, done, err, wr_en;
    logic [4:0]   wr_addr;
    logic [W-1:0] wr_data;

    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t sb[$];
    exp_t mon_e;

    xpb_table_gen dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .modulus (modulus),
        .base    (base),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d act=%h..%h exp=%h..%h", name, cyc,
                     act[W-1:W-64], act[63:0], exp[W-1:W-64], exp[63:0]);
        end
    endtask

    function automatic logic [W-1:0] ref_entry(input int j, input logic [W-1:0] b,
                                               input logic [W-1:0] m);
        logic [W+5:0] jj, bb, mm, r;
        jj = (W+6)'(j);
        bb = {6'd0, b};
        mm = {6'd0, m};
        r  = (jj * bb) % mm;
        return r[W-1:0];
    endfunction

    // Monitor: every write or done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (wr_en || done) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_output cyc=%0d wr_en=%0b done=%0b addr=%0d exp=none",
                         cyc, wr_en, done, wr_addr);
            end else begin
                mon_e = sb.pop_front();
                chk("kind_is_done", W'(done), W'(mon_e.is_done));
                chk("event_cycle", W'(cyc), W'(mon_e.cyc));
                if (mon_e.is_done) begin
                    chk("err_at_done", W'(err), W'(mon_e.err));
                    chk("busy_at_done", W'(busy), '0);
                end else begin
                    chk("wr_addr", W'(wr_addr), W'(mon_e.addr));
                    chk("wr_data", wr_data, mon_e.data);
                    chk("busy_during_write", W'(busy), W'(1));
                end
            end
        end
    end

    task automatic go(input logic [W-1:0] m, input logic [W-1:0] b, output int t0);
        @(negedge clk); #2;
        modulus = m;
        base    = b;
        start   = 1'b1;
        t0      = cyc + 1;
        @(negedge clk); #2;
        start   = 1'b0;
    endtask

    task automatic push_w(input int t0, input int j, input logic [W-1:0] d);
        sb.push_back('{1'b0, 5'(j), d, 1'b0, t0 + 1 + 2*j});
    endtask

    task automatic push_done(input int t0, input bit e, input int dly);
        sb.push_back('{1'b1, 5'd0, '0, e, t0 + dly});
    endtask

    task automatic push_model(input int t0, input logic [W-1:0] m, input logic [W-1:0] b);
        for (int j = 0; j < 32; j++) push_w(t0, j, ref_entry(j, b, m));
        push_done(t0, 1'b0, 64);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout pending=%0d required=0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int           t0;
        int           t13[13];
        logic [W-1:0] m2, b2, m3, b3;

        t13 = '{0, 5, 10, 2, 7, 12, 4, 9, 1, 6, 11, 3, 8};
        m2  = {1'b1, {(W-1){1'b0}}} + W'(3);
        b2  = {1'b1, {(W-1){1'b0}}} + W'(1);
        m3  = '1;
        b3  = m3 - W'(1);

        repeat (3) @(negedge clk);
        chk("reset_busy", W'(busy), '0);
        chk("reset_done", W'(done), '0);
        chk("reset_err", W'(err), '0);
        chk("reset_wr_en", W'(wr_en), '0);
        chk("reset_wr_addr", W'(wr_addr), '0);
        chk("reset_wr_data", wr_data, '0);
        #2 rst_n = 1'b1;

        // N=13, base=5: hand table of j*5 mod 13
        go(W'(13), W'(5), t0);
        for (int j = 0; j < 32; j++) push_w(t0, j, W'(t13[j % 13]));
        push_done(t0, 1'b0, 64);
        drain("n13");

        // Carry out of the wide adder
        go(m2, b2, t0);
        push_model(t0, m2, b2);
        drain("carry");

        // base = N-1 with N = 2^1024-1: entry j = N - j
        go(m3, b3, t0);
        push_w(t0, 0, '0);
        for (int j = 1; j < 32; j++) push_w(t0, j, m3 - W'(j));
        push_done(t0, 1'b0, 64);
        drain("nminus1");

        // base == modulus: no writes, err with done at T0+2
        go(W'(7), W'(7), t0);
        push_done(t0, 1'b1, 2);
        drain("err_eq");
        repeat (3) @(negedge clk);
        chk("err_holds", W'(err), W'(1));

        // modulus = 0
        go('0, '0, t0);
        push_done(t0, 1'b1, 2);
        drain("err_zero");

        // Second start mid-run is ignored
        go(W'(97), W'(40), t0);
        push_model(t0, W'(97), W'(40));
        while (cyc < t0 + 19) @(negedge clk);
        #2;
        start   = 1'b1;
        modulus = W'(13);
        base    = W'(5);
        @(negedge clk); #2;
        start = 1'b0;
        drain("restart_ignored");

        // Reset mid-run, then a clean full rerun
        go(m2, b2, t0);
        for (int j = 0; j < 10; j++) push_w(t0, j, ref_entry(j, b2, m2));
        while (cyc < t0 + 20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", W'(busy), '0);
        chk("abort_wr_en", W'(wr_en), '0);
        chk("abort_wr_addr", W'(wr_addr), '0);
        chk("abort_wr_data", wr_data, '0);
        chk("abort_pending", W'(sb.size()), '0);
        sb.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        go(m2, b2, t0);
        push_model(t0, m2, b2);
        drain("after_reset");

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
